seq_shift_add_multiplier: RTL and testbench
===========================================

// Module: seq_shift_add_multiplier
// PURPOSE
//   Unsigned 32x32 -> 64-bit multi-cycle multiplier built around the existing
//   32-bit ripple-carry adder. One shift-add iteration per clock.
//   Sits between an operand producer and a result consumer, with a
//   valid/ready handshake on each side. Holds one operation at a time.
// PARAMETERS
//   WIDTH  32  operand width; fixed at 32 by the adder instance (no other value supported)
// PORTS
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operands a/b valid
//   in_ready   out  1   block can accept operands (high only in IDLE)
//   a          in   32  multiplicand, unsigned
//   b          in   32  multiplier, unsigned
//   out_valid  out  1   product valid (high only in DONE)
//   out_ready  in   1   consumer accepts product
//   product    out  64  a*b, unsigned
//   busy       out  1   high in RUN or DONE
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, count=0, M/P/Q regs=0, product=0,
//     out_valid=0, busy=0, in_ready=1 (decoded from state). Aborts any op in flight.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid && in_ready at an edge: M<=a, Q<=b, P<=0,
//     count<=0, state<=RUN. in_valid low: stay.
//   RUN (32 iterations, one per edge): adder inputs a=P, b=(Q[0] ? M : 0), cin=0.
//     {P,Q} <= {cout, sum, Q[31:1]}. Adder cout becomes P[31] after the shift,
//     so no carry is lost. count<=count+1.
//     On the iteration with count==31: product <= the shifted {P,Q} value and
//     state <= DONE. in_valid is ignored throughout RUN.
//   DONE: out_valid=1; product stable until the handshake. in_ready=0, so
//     in_valid is ignored. On out_ready: state<=IDLE. The next accept is
//     possible one edge later.
//   Latency: accept edge = E0. out_valid is high right after edge E32
//     (exactly 32 edges later). Throughput: 1 op per >=34 cycles.
//   product holds its last result through IDLE/RUN and changes only on
//     RUN->DONE or reset.
//   count is 6 bits. It never wraps: it is cleared on accept.
//   Inputs in IDLE with in_valid=0 are don't-care. a/b are sampled only
//     on the accept edge.
//   Reset asserted mid-RUN or in DONE: immediate return to reset values.
//     The partial result is discarded and out_valid is never pulsed.
// STRUCTURE
//   Shared package/include coa_defs.vh holds:
//     - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
//     - MUL_ITER=32, CNT_W=6
//   One sub-module instance: ripple_carry_adder_32bit (u_add, cin tied 0).
//   Operand gating (Q[0] ? M : 0), shift registers, counter and FSM stay in
//     this module.
// TESTING
//   1. a=3, b=5 -> product=64'd15; out_valid rises exactly 32 edges after
//      the accept edge.
//   2. a=b=32'hFFFFFFFF -> product=64'hFFFFFFFE_00000001 (adder cout into
//      the upper half each iteration).
//   3. a=0, b=32'h12345678 -> 0; a=32'h80000000, b=2 -> 64'h00000001_00000000.
//   4. out_ready held low 10 cycles in DONE, in_valid pulsed meanwhile ->
//      out_valid/product stable, in_ready=0, no new accept. Then out_ready=1
//      -> IDLE and in_ready=1 next cycle.
//   5. rst_n low at RUN iteration 10 -> out_valid=0, product=0, in_ready=1
//      at once. A following a=7, b=6 -> 42.
//   6. 1000 back-to-back random ops with random out_ready stalls ->
//      every product equals the 64-bit model; no op dropped or duplicated.

Source files
------------

// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared constants for the sequential shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_shift_add_multiplier_pkg;

    // Operand and product widths; the adder instance fixes these at 32/64
    localparam int OP_W   = 32;
    localparam int PROD_W = 2 * OP_W;

    // One shift-add iteration per operand bit
    localparam int MUL_ITER = 32;
    localparam int CNT_W    = 6;

    // FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result handshake bundle between producer, multiplier and consumer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the product side.
interface seq_shift_add_multiplier_if;
    import seq_shift_add_multiplier_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] product;
    logic              busy;

    // Multiplier side
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );

    // Producer/consumer side
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/seq_shift_add_multiplier_rca.sv
// 32-bit ripple-carry adder used by the shift-add datapath.
// Latency: combinational.
// Backpressure: none.
module ripple_carry_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    // Bit-serial carry chain, one full adder per bit
    always_comb begin : rc_chain
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned 32x32->64 multiplier, one shift-add iteration per clock.
// Latency: out_valid rises 32 edges after the accept edge; one op in flight.
// Backpressure: in_ready only in IDLE; product held in DONE until out_ready.
module seq_shift_add_multiplier
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    seq_shift_add_multiplier_if.slave    bus
);

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   p_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [2*WIDTH-1:0] product_reg;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [2*WIDTH-1:0] shifted;
    logic               last_iter;

    // Gate the multiplicand by the current multiplier LSB
    assign add_b = q_reg[0] ? m_reg : '0;

    ripple_carry_adder_32bit u_add (
        .a    (p_reg),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // The adder carry lands in P's MSB after the right shift, so nothing is lost
    assign shifted   = {cout, sum, q_reg[WIDTH-1:1]};
    assign last_iter = (count == CNT_W'(MUL_ITER - 1));

    // FSM, shift registers, iteration counter and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            count       <= '0;
            m_reg       <= '0;
            p_reg       <= '0;
            q_reg       <= '0;
            product_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        m_reg <= bus.a;
                        q_reg <= bus.b;
                        p_reg <= '0;
                        count <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    p_reg <= shifted[2*WIDTH-1:WIDTH];
                    q_reg <= shifted[WIDTH-1:0];
                    count <= count + CNT_W'(1);
                    if (last_iter) begin
                        product_reg <= shifted;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode directly from state
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state == ST_RUN) || (state == ST_DONE);
    assign bus.product   = product_reg;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed and random checks of the sequential shift-add multiplier.
// Latency checked: 32 edges from accept to out_valid.
// Backpressure checked: DONE holds under out_ready stalls, in_valid ignored.
module tb_seq_shift_add_multiplier;
    import seq_shift_add_multiplier_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_shift_add_multiplier_if bus ();

    seq_shift_add_multiplier #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and wait through the accept edge
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        check("busy_after_accept", 64'(bus.busy), 64'd1);
        check("in_ready_in_run", 64'(bus.in_ready), 64'd0);
    endtask

    // Count edges from accept until out_valid (bounded)
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.out_valid && lat < 100);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int stall);
        int lat;
        start_op(a, b);
        wait_done(lat);
        check("latency", 64'(lat), 64'd32);
        check("product", bus.product, exp);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_after_hs", 64'(bus.out_valid), 64'd0);
        check("in_ready_after_hs", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] held;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_product", bus.product, 64'd0);
        rst_n = 1'b1;
        tick();

        // Directed vectors
        run_op(32'd3, 32'd5, 64'd15, 0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 2);
        run_op(32'd0, 32'h12345678, 64'd0, 0);
        run_op(32'h80000000, 32'd2, 64'h00000001_00000000, 1);

        // Consumer stall in DONE with in_valid pulsed meanwhile
        start_op(32'd1000, 32'd1000);
        wait_done(lat);
        check("stall_latency", 64'(lat), 64'd32);
        held = 64'd1000000;
        check("stall_product", bus.product, held);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.a        = 32'(i + 1);
            bus.b        = 32'(i + 2);
            tick();
            check("done_out_valid", 64'(bus.out_valid), 64'd1);
            check("done_in_ready", 64'(bus.in_ready), 64'd0);
            check("done_product", bus.product, held);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
        check("release_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        check("no_ghost_accept", 64'(bus.busy), 64'd0);
        check("idle_product_held", bus.product, held);

        // Reset mid-RUN discards the partial result
        start_op(32'hDEADBEEF, 32'h00001234);
        repeat (9) tick();
        check("midrun_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrun_rst_product", bus.product, 64'd0);
        check("midrun_rst_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(32'd7, 32'd6, 64'd42, 0);

        // Back-to-back random ops with random consumer stalls
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, 64'(ra) * 64'(rb), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
